// File: rtl/alu_pipe_pkg.sv
// Shared types for the handshaked ALU pipe: opcodes, FSM states, flag bundle.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_SRA = 4'd7,
    OP_MUL = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
    logic error;
  } alu_flags_t;

  localparam int OP_LAST_LEGAL = 8;

  // MUL counts as illegal when the multiplier is not built.
  function automatic logic op_is_legal(input alu_op_e op, input bit mul_en);
    if (op == OP_MUL) return logic'(mul_en);
    return (32'(op) <= OP_LAST_LEGAL);
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Input and output valid/ready channels of alu_pipe bundled in one interface.
interface alu_pipe_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  import alu_pipe_pkg::*;

  logic             in_valid;
  logic             in_ready;
  alu_op_e          in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [WIDTH-1:0] out_result_hi;
  logic [TAG_W-1:0] out_tag;
  logic             out_carry;
  logic             out_zero;
  logic             out_overflow;
  logic             out_error;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_result_hi, out_tag,
           out_carry, out_zero, out_overflow, out_error
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_result_hi, out_tag,
           out_carry, out_zero, out_overflow, out_error
  );

endinterface

// File: rtl/alu_pipe_mul.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
module alu_pipe_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  // done flags the cycle whose step finishes the product, so the consumer
  // registers prod (the combinational final sum) WIDTH edges after start.
  assign done = (r_cnt == CNT_W'(1));
  assign prod = w_acc_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (start) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_cnt    <= CNT_W'(WIDTH);
    end else if (r_cnt != '0) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: one-cycle ops, optional WIDTH-cycle multiply, depth-1 result.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int TAG_W  = 4,
  parameter bit MUL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  alu_pipe_if.slave  bus
);

  localparam int SH_W = $clog2(WIDTH);

  state_e             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_res, r_res_hi;
  logic [TAG_W-1:0]   r_tag;
  alu_flags_t         r_flags;

  logic               w_in_ready, w_accept, w_is_mul;
  logic               w_load_alu, w_load_mul;
  logic               w_mul_start, w_mul_done;
  logic [2*WIDTH-1:0] w_mul_prod;

  logic [SH_W-1:0]    w_sh;
  logic [WIDTH:0]     w_sum, w_diff, w_shl, w_shr, w_sra;
  logic [WIDTH-1:0]   w_res;
  alu_flags_t         w_flags;

  // Handshake
  assign w_in_ready  = reset && (r_state != ST_MUL) &&
                       ((r_state == ST_IDLE) || bus.out_ready);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_is_mul    = MUL_EN && (bus.in_op == OP_MUL);
  assign w_mul_start = w_accept && w_is_mul;
  assign w_load_alu  = w_accept && !w_is_mul;
  assign w_load_mul  = (r_state == ST_MUL) && w_mul_done;

  // Single-cycle datapath; shifts are widened by one bit to catch carry-out.
  always_comb begin
    w_sh    = bus.in_b[SH_W-1:0];
    w_sum   = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    w_diff  = {1'b0, bus.in_a} - {1'b0, bus.in_b};
    w_shl   = {1'b0, bus.in_a} << w_sh;
    w_shr   = {bus.in_a, 1'b0} >> w_sh;
    w_sra   = $signed({bus.in_a, 1'b0}) >>> w_sh;
    w_res   = '0;
    w_flags = '0;
    unique case (bus.in_op)
      OP_ADD: begin
        w_res            = w_sum[WIDTH-1:0];
        w_flags.carry    = w_sum[WIDTH];
        w_flags.overflow = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != bus.in_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res            = w_diff[WIDTH-1:0];
        w_flags.carry    = w_diff[WIDTH];
        w_flags.overflow = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != bus.in_a[WIDTH-1]);
      end
      OP_AND: w_res = bus.in_a & bus.in_b;
      OP_OR:  w_res = bus.in_a | bus.in_b;
      OP_XOR: w_res = bus.in_a ^ bus.in_b;
      OP_SHL: begin
        w_res         = w_shl[WIDTH-1:0];
        w_flags.carry = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res         = w_shr[WIDTH:1];
        w_flags.carry = w_shr[0];
      end
      OP_SRA: begin
        w_res         = w_sra[WIDTH:1];
        w_flags.carry = w_sra[0];
      end
      default: ;
    endcase
    if (!op_is_legal(bus.in_op, MUL_EN)) begin
      w_res         = '0;
      w_flags       = '0;
      w_flags.error = 1'b1;
    end
    w_flags.zero = (w_res == '0);
  end

  generate
    if (MUL_EN) begin : g_mul
      alu_pipe_mul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (w_mul_start),
        .a     (bus.in_a),
        .b     (bus.in_b),
        .done  (w_mul_done),
        .prod  (w_mul_prod)
      );
    end else begin : g_no_mul
      assign w_mul_done = 1'b0;
      assign w_mul_prod = '0;
    end
  endgenerate

  // FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_is_mul ? ST_MUL : ST_DONE;
      ST_MUL:  if (w_mul_done) w_state_nxt = ST_DONE;
      ST_DONE: begin
        if (w_accept)           w_state_nxt = w_is_mul ? ST_MUL : ST_DONE;
        else if (bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result register; tag is latched at accept so MUL carries it across.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_res    <= '0;
      r_res_hi <= '0;
      r_tag    <= '0;
      r_flags  <= '0;
    end else if (w_accept) begin
      r_tag <= bus.in_tag;
      if (w_load_alu) begin
        r_res    <= w_res;
        r_res_hi <= '0;
        r_flags  <= w_flags;
      end
    end else if (w_load_mul) begin
      r_res          <= w_mul_prod[WIDTH-1:0];
      r_res_hi       <= w_mul_prod[2*WIDTH-1:WIDTH];
      r_flags        <= '0;
      r_flags.carry  <= (w_mul_prod[2*WIDTH-1:WIDTH] != '0);
      r_flags.zero   <= (w_mul_prod == '0);
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = (r_state == ST_DONE);
  assign bus.out_result    = r_res;
  assign bus.out_result_hi = r_res_hi;
  assign bus.out_tag       = r_tag;
  assign bus.out_carry     = r_flags.carry;
  assign bus.out_zero      = r_flags.zero;
  assign bus.out_overflow  = r_flags.overflow;
  assign bus.out_error     = r_flags.error;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: one DUT with the multiplier, one without.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int W = 8;
  localparam int T = 4;

  logic clk;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  alu_pipe_if #(.WIDTH(W), .TAG_W(T)) bus  ();
  alu_pipe_if #(.WIDTH(W), .TAG_W(T)) bus0 ();

  alu_pipe #(.WIDTH(W), .TAG_W(T), .MUL_EN(1'b1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  alu_pipe #(.WIDTH(W), .TAG_W(T), .MUL_EN(1'b0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input alu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [T-1:0] tag);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
  endtask

  task automatic send(input alu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [T-1:0] tag);
    drive(op, a, b, tag);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // {valid, result, hi, tag, carry, zero, overflow, error}
  function automatic logic [63:0] pack_out(input logic v, input logic [W-1:0] r,
      input logic [W-1:0] h, input logic [T-1:0] t, input logic c, input logic z,
      input logic o, input logic e);
    return 64'({v, r, h, t, c, z, o, e});
  endfunction

  function automatic logic [63:0] obs_out();
    return pack_out(bus.out_valid, bus.out_result, bus.out_result_hi, bus.out_tag,
                    bus.out_carry, bus.out_zero, bus.out_overflow, bus.out_error);
  endfunction

  alu_op_e          s_op  [6];
  logic [W-1:0]     s_a   [6];
  logic [W-1:0]     s_b   [6];
  logic [W-1:0]     s_res [6];
  logic             s_c   [6];

  initial begin
    logic saw_valid;

    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = OP_ADD; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;
    bus.out_ready = 1'b1;
    bus0.in_valid = 1'b0; bus0.in_op = OP_ADD; bus0.in_a = '0; bus0.in_b = '0; bus0.in_tag = '0;
    bus0.out_ready = 1'b1;

    #12;
    chk("reset_outputs", obs_out(), pack_out(0, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0));
    chk("reset_in_ready", {bus.in_ready, bus0.in_ready, bus0.out_valid}, 3'b000);
    tick();
    reset = 1'b1;
    #1;
    chk("idle_in_ready", bus.in_ready, 1'b1);

    // ADD overflow to zero, then signed-overflowing SUB
    send(OP_ADD, 8'hFF, 8'h01, 4'd3);
    chk("add_ff_01", obs_out(), pack_out(1, 8'h00, 8'h00, 4'd3, 1, 1, 0, 0));
    send(OP_SUB, 8'h80, 8'h01, 4'd4);
    chk("sub_80_01", obs_out(), pack_out(1, 8'h7F, 8'h00, 4'd4, 0, 0, 1, 0));

    // Streaming at one op per clock
    s_op[0] = OP_AND; s_a[0] = 8'hF0; s_b[0] = 8'h3C; s_res[0] = 8'h30; s_c[0] = 1'b0;
    s_op[1] = OP_OR;  s_a[1] = 8'hF0; s_b[1] = 8'h0F; s_res[1] = 8'hFF; s_c[1] = 1'b0;
    s_op[2] = OP_XOR; s_a[2] = 8'hAA; s_b[2] = 8'hAA; s_res[2] = 8'h00; s_c[2] = 1'b0;
    s_op[3] = OP_SHL; s_a[3] = 8'h81; s_b[3] = 8'h01; s_res[3] = 8'h02; s_c[3] = 1'b1;
    s_op[4] = OP_SHR; s_a[4] = 8'h81; s_b[4] = 8'h01; s_res[4] = 8'h40; s_c[4] = 1'b1;
    s_op[5] = OP_SRA; s_a[5] = 8'h90; s_b[5] = 8'h02; s_res[5] = 8'hE4; s_c[5] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("stream_ready_%0d", i), bus.in_ready, 1'b1);
      drive(s_op[i], s_a[i], s_b[i], 4'(5 + i));
      tick();
      chk($sformatf("stream_%0d", i), obs_out(),
          pack_out(1, s_res[i], 8'h00, 4'(5 + i), s_c[i], s_res[i] == 8'h00, 0, 0));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("stream_drain_idle", bus.out_valid, 1'b0);

    // MUL: WIDTH cycles with in_ready low and no result
    send(OP_MUL, 8'hFF, 8'hFF, 4'd11);
    for (int k = 0; k < W; k++) begin
      chk($sformatf("mul_wait_%0d", k), {bus.out_valid, bus.in_ready}, 2'b00);
      tick();
    end
    chk("mul_ff_ff", obs_out(), pack_out(1, 8'h01, 8'hFE, 4'd11, 1, 0, 0, 0));
    tick();

    // Backpressure: result holds, offered op waits, then enters on release edge
    bus.out_ready = 1'b0;
    send(OP_ADD, 8'h02, 8'h03, 4'd12);
    drive(OP_ADD, 8'h07, 8'h01, 4'd13);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold_%0d", k), {obs_out(), bus.in_ready},
          {pack_out(1, 8'h05, 8'h00, 4'd12, 0, 0, 0, 0), 1'b0});
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_next_op", obs_out(), pack_out(1, 8'h08, 8'h00, 4'd13, 0, 0, 0, 0));
    tick();

    // Illegal opcode, and MUL on the build without a multiplier
    bus0.in_valid = 1'b1; bus0.in_op = OP_MUL; bus0.in_a = 8'hFF; bus0.in_b = 8'hFF;
    bus0.in_tag = 4'd2;
    send(alu_op_e'(4'd12), 8'h05, 8'h03, 4'd14);
    bus0.in_valid = 1'b0;
    chk("illegal_op12", obs_out(), pack_out(1, 8'h00, 8'h00, 4'd14, 0, 1, 0, 1));
    chk("mul_disabled",
        pack_out(bus0.out_valid, bus0.out_result, bus0.out_result_hi, bus0.out_tag,
                 bus0.out_carry, bus0.out_zero, bus0.out_overflow, bus0.out_error),
        pack_out(1, 8'h00, 8'h00, 4'd2, 0, 1, 0, 1));
    tick();

    // Reset during the 4th MUL cycle discards the pending product
    send(OP_MUL, 8'h03, 8'h04, 4'd15);
    tick(); tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_mul", {obs_out(), bus.in_ready},
        {pack_out(0, 8'h00, 8'h00, 4'h0, 0, 0, 0, 0), 1'b0});
    tick();
    reset = 1'b1;
    #1;
    chk("rst_release_ready", bus.in_ready, 1'b1);
    send(OP_ADD, 8'h01, 8'h01, 4'd1);
    chk("post_rst_add", obs_out(), pack_out(1, 8'h02, 8'h00, 4'd1, 0, 0, 0, 0));
    saw_valid = 1'b0;
    for (int k = 0; k < W + 2; k++) begin
      tick();
      saw_valid = saw_valid | bus.out_valid;
    end
    chk("no_stale_mul", saw_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
